// File: rtl/counter_res_pkg.sv
// Shared default sizing for the step accumulator and its restart timer.
package counter_res_pkg;
  localparam int WIDTH_DEF  = 5;
  localparam int STEP_W_DEF = 4;
  localparam int PERIOD_DEF = 20;
endpackage

// File: rtl/counter_res_if.sv
// Data bundle between the step source and the accumulator. There is no handshake:
// 'in' is sampled at every rising edge; out/temp/reset are valid all the time.
interface counter_res_if
  import counter_res_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF
) ();
  logic [STEP_W-1:0] in;
  logic [WIDTH-1:0]  out;
  logic [WIDTH-1:0]  temp;
  logic              reset;

  modport master (output in, input out, input temp, input reset);
  modport slave  (input in, output out, output temp, output reset);
endinterface

// File: rtl/counter_res_reset_timer.sv
// Free-running restart timer: counts 0..PERIOD-1, flags the wrap edge and
// produces a one-cycle restart strobe that also covers the reset period.
module counter_res_reset_timer
  import counter_res_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  output logic [WIDTH-1:0] temp_o,
  output logic             wrap_o,
  output logic             reset_o
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

  logic [WIDTH-1:0] temp_q, temp_d;
  logic             wrap_q, wrap;

  // With PERIOD = 2**WIDTH, LAST is all-ones and temp_q + 1 rolls over to 0 anyway.
  always_comb begin
    wrap   = (temp_q == LAST);
    temp_d = wrap ? '0 : temp_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      temp_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      temp_q <= temp_d;
      wrap_q <= wrap;
    end
  end

  assign temp_o  = temp_q;
  assign wrap_o  = wrap;
  assign reset_o = rstn | wrap_q;
endmodule

// File: rtl/counter_res.sv
// Step accumulator: adds 'in' every clock, cleared by the restart timer every PERIOD clocks.
module counter_res
  import counter_res_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF,
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  counter_res_if.slave bus
);
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] temp;
  logic             wrap;
  logic             reset;

  counter_res_reset_timer #(
    .WIDTH  (WIDTH),
    .PERIOD (PERIOD)
  ) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .temp_o  (temp),
    .wrap_o  (wrap),
    .reset_o (reset)
  );

  // The clear takes priority over the step on the wrap edge.
  always_comb begin
    out_d = wrap ? '0 : out_q + WIDTH'(bus.in);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) out_q <= '0;
    else      out_q <= out_d;
  end

  assign bus.out   = out_q;
  assign bus.temp  = temp;
  assign bus.reset = reset;
endmodule

// File: tb/tb_counter_res.sv
// Bench for counter_res: reference model feeds an expected queue, compared after every edge.
module tb_counter_res;
  localparam int WIDTH  = 5;
  localparam int STEP_W = 4;
  localparam int PERIOD = 20;
  localparam int MODV   = 32;
  localparam int EW     = 2 * WIDTH + 1;

  logic clk;
  logic rstn;

  counter_res_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  counter_res #(.WIDTH(WIDTH), .STEP_W(STEP_W), .PERIOD(PERIOD)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // scoreboard: {reset, temp, out}
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int m_temp = 0;
  int m_out  = 0;
  int m_wrapq = 0;
  int edge_n = 0;

  task automatic model_reset();
    m_temp = 0; m_out = 0; m_wrapq = 0; edge_n = 0;
  endtask

  // Drive one step before the next edge, predict, then compare after the edge.
  task automatic step(input int v);
    logic [EW-1:0] exp, got;
    int wrap;
    bus.in = STEP_W'(v);
    wrap = (m_temp == PERIOD - 1) ? 1 : 0;
    m_out   = wrap ? 0 : (m_out + v) % MODV;
    m_temp  = wrap ? 0 : (m_temp + 1) % MODV;
    m_wrapq = wrap;
    edge_n++;
    exp_q.push_back({1'(m_wrapq), WIDTH'(m_temp), WIDTH'(m_out)});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    got = {bus.reset, bus.temp, bus.out};
    checks++;
    if (got !== exp)
      $display("FAIL edge%0d {reset,temp,out} got=%0d,%0d,%0d exp=%0d,%0d,%0d", edge_n,
               got[EW-1], got[EW-2:WIDTH], got[WIDTH-1:0], exp[EW-1], exp[EW-2:WIDTH], exp[WIDTH-1:0]);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    bus.in = 4'd4;
    model_reset();
    #5;
    checks++;
    if ({bus.reset, bus.temp, bus.out} !== {1'b1, 5'd0, 5'd0})
      $display("FAIL reset_t5 got reset=%0b temp=%0d out=%0d exp 1,0,0", bus.reset, bus.temp, bus.out);
    else passes++;
    #7;  // after the edge at 10 ns, still in reset
    checks++;
    if ({bus.reset, bus.temp, bus.out} !== {1'b1, 5'd0, 5'd0})
      $display("FAIL reset_t12 got reset=%0b temp=%0d out=%0d exp 1,0,0", bus.reset, bus.temp, bus.out);
    else passes++;
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.reset !== 1'b0) $display("FAIL reset_release got reset=%0b exp 0", bus.reset);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_accumulate();
    for (int k = 1; k <= 9; k++) begin
      step(4);
      checks++;
      if (bus.out !== WIDTH'((4 * k) % 32) || bus.temp !== WIDTH'(k))
        $display("FAIL accum_k%0d got out=%0d temp=%0d exp out=%0d temp=%0d", k, bus.out, bus.temp, (4 * k) % 32, k);
      else passes++;
    end
  endtask

  task automatic test_restart();
    while (edge_n < 19) step(4);
    step(4);  // edge 20
    checks++;
    if (bus.temp !== 5'd0 || bus.out !== 5'd0 || bus.reset !== 1'b1)
      $display("FAIL restart_e20 got temp=%0d out=%0d reset=%0b exp 0,0,1", bus.temp, bus.out, bus.reset);
    else passes++;
    step(4);  // edge 21
    checks++;
    if (bus.temp !== 5'd1 || bus.out !== 5'd4 || bus.reset !== 1'b0)
      $display("FAIL restart_e21 got temp=%0d out=%0d reset=%0b exp 1,4,0", bus.temp, bus.out, bus.reset);
    else passes++;
    while (edge_n < 50) step(4);
  endtask

  task automatic test_step_change();
    int guard = 0;
    while (m_out != 12 && guard < 40) begin
      step(4);
      guard++;
    end
    checks++;
    if (bus.out !== 5'd12) $display("FAIL step_reach12 got out=%0d exp 12", bus.out);
    else passes++;
    step(15);
    checks++;
    if (bus.out !== 5'd27) $display("FAIL step_chg1 got out=%0d exp 27", bus.out);
    else passes++;
    step(15);
    checks++;
    if (bus.out !== 5'd10) $display("FAIL step_chg2 got out=%0d exp 10", bus.out);
    else passes++;
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (m_temp != 9 && guard < 40) begin
      step($urandom_range(1, 15));
      guard++;
    end
    checks++;
    if (bus.temp !== 5'd9) $display("FAIL mid_pre got temp=%0d exp 9", bus.temp);
    else passes++;
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.out !== 5'd0 || bus.temp !== 5'd0 || bus.reset !== 1'b1)
      $display("FAIL mid_async got out=%0d temp=%0d reset=%0b exp 0,0,1", bus.out, bus.temp, bus.reset);
    else passes++;
    model_reset();
    #4;
    rstn = 1'b0;
    step(4);
    checks++;
    if (bus.temp !== 5'd1 || bus.out !== 5'd4)
      $display("FAIL mid_restart got temp=%0d out=%0d exp 1,4", bus.temp, bus.out);
    else passes++;
  endtask

  task automatic test_zero_step();
    int strobes = 0;
    int bad = 0;
    for (int i = 0; i < 45; i++) begin  // edges 2..46
      step(0);
      if (bus.reset === 1'b1) strobes++;
      if (edge_n >= 20 && bus.out !== 5'd0) bad++;
    end
    checks++;
    if (strobes !== 2) $display("FAIL zero_strobes got=%0d exp=2", strobes);
    else passes++;
    checks++;
    if (bad !== 0) $display("FAIL zero_hold got nonzero_count=%0d exp=0", bad);
    else passes++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) step($urandom_range(0, 15));
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_restart();
    test_step_change();
    test_mid_reset();
    test_zero_step();
    test_back_to_back();
    checks++;
    if (exp_q.size() !== 0) $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
